axi_read_arbiter: RTL

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_read_arbiter_if.sv | 65 ++++++
 rtl/axi_read_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter_if.sv
// ============================================================================
// axi_read_arbiter_if
// ----------------------------------------------------------------------------
// Purpose:
//   Bundles the AXI4 read-address (AR) and read-data (R) channels of one AXI
//   link. The arbiter uses this interface for its two requester links and for
//   its single memory-side link.
//
// Parameters:
//   ADDR_WIDTH - araddr width
//   DATA_WIDTH - rdata width
//   ID_WIDTH   - arid / rid width. The memory-side link carries one more ID
//                bit than a requester link, which holds the port number.
//
// Signals:
//   AR channel : arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
//                arvalid (initiator -> target), arready (target -> initiator)
//   R channel  : rid, rdata, rresp, rlast, rvalid (target -> initiator),
//                rready (initiator -> target)
//
// Modports:
//   master - the side that issues read requests and consumes read data
//   slave  - the side that accepts read requests and returns read data
// ============================================================================
interface axi_read_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    // AR channel
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    // R channel
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        output arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// ============================================================================
// axi_read_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Merges two AXI4 read requesters onto one memory-side AXI4 read port.
//   AR requests are arbitrated round-robin and registered toward memory; the
//   port number is prepended to the forwarded ID. R beats are routed back
//   combinationally using that extra ID bit.
//
// Parameters:
//   ADDR_WIDTH      - address width (default 32)
//   DATA_WIDTH      - R data width (default 32)
//   ID_WIDTH        - requester ID width (default 8); memory side is ID_WIDTH+1
//   MAX_OUTSTANDING - per-port outstanding burst limit (default 4)
//
// Ports:
//   aclk   - single clock for all logic
//   reset  - asynchronous, active-high reset
//   s0_axi - requester 0 AR/R link (slave modport)
//   s1_axi - requester 1 AR/R link (slave modport)
//   m_axi  - memory-side AR/R link (master modport), ID width ID_WIDTH+1
//
// Configuration:
//   AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN
//     Defined   : each port tracks outstanding bursts (incremented on its AR
//                 grant, decremented on its last R beat); a port that has
//                 MAX_OUTSTANDING bursts in flight is not granted.
//     Undefined : no counters; a port is eligible whenever arvalid is high.
//
// Timing:
//   IDLE  : an eligible request is granted, its arready pulses for that one
//           cycle and its fields are captured; next state is ISSUE.
//   ISSUE : m_axi.arvalid is high with stable fields until m_axi.arready.
//   A request therefore occupies at least two cycles.
// ============================================================================
module axi_read_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               aclk,
    input  logic               reset,
    axi_read_arbiter_if.slave  s0_axi,
    axi_read_arbiter_if.slave  s1_axi,
    axi_read_arbiter_if.master m_axi
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Captured AR request, including the port it came from.
    typedef struct packed {
        logic                  port;
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
    } ar_req_t;

    state_t  state;
    state_t  state_next;

    logic    elig0;
    logic    elig1;
    logic    grant_en;     // a grant is made this cycle
    logic    grant_port;   // port being granted this cycle
    logic    last_grant;   // port that won the most recent grant

    ar_req_t ar_sel;       // fields of the port being granted
    ar_req_t ar_q;         // fields presented on m_axi

    logic    r_sel;        // port addressed by the current R beat

    // ------------------------------------------------------------------------
    // Eligibility
    // ------------------------------------------------------------------------
`ifdef AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             inc0;
    logic             inc1;
    logic             dec0;
    logic             dec1;

    assign inc0 = grant_en && !grant_port;
    assign inc1 = grant_en &&  grant_port;

    // A burst is retired by the handshaken last beat routed to its port.
    assign dec0 = m_axi.rvalid && m_axi.rready && m_axi.rlast && !r_sel;
    assign dec1 = m_axi.rvalid && m_axi.rready && m_axi.rlast &&  r_sel;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            // Simultaneous increment and decrement leaves the count unchanged.
            // A stray last beat with nothing outstanding does not wrap.
            if (inc0 && !dec0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end else if (dec0 && !inc0 && (cnt0 != '0)) begin
                cnt0 <= cnt0 - CNT_W'(1);
            end

            if (inc1 && !dec1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end else if (dec1 && !inc1 && (cnt1 != '0)) begin
                cnt1 <= cnt1 - CNT_W'(1);
            end
        end
    end

    assign elig0 = s0_axi.arvalid && (cnt0 < CNT_MAX);
    assign elig1 = s1_axi.arvalid && (cnt1 < CNT_MAX);
`else
    assign elig0 = s0_axi.arvalid;
    assign elig1 = s1_axi.arvalid;
`endif

    // ------------------------------------------------------------------------
    // AR state machine
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking (<=) assignments so
    // every register samples values from before the clock edge.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        grant_port = 1'b0;

        case (state)
            IDLE: begin
                // The reset term keeps arready low while reset is asserted
                // even though the state already reads IDLE.
                if (!reset && (elig0 || elig1)) begin
                    grant_en   = 1'b1;
                    // On a tie the port that did not win last time goes next;
                    // otherwise the single eligible port wins.
                    grant_port = (elig0 && elig1) ? ~last_grant : elig1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (m_axi.arready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Last-grant pointer starts at port 1 so port 0 wins the first tie.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant_en) begin
            last_grant <= grant_port;
        end
    end

    // ------------------------------------------------------------------------
    // AR payload capture
    // ------------------------------------------------------------------------
    always_comb begin
        if (grant_port) begin
            ar_sel.port  = 1'b1;
            ar_sel.id    = s1_axi.arid;
            ar_sel.addr  = s1_axi.araddr;
            ar_sel.len   = s1_axi.arlen;
            ar_sel.size  = s1_axi.arsize;
            ar_sel.burst = s1_axi.arburst;
            ar_sel.lock  = s1_axi.arlock;
            ar_sel.cache = s1_axi.arcache;
            ar_sel.prot  = s1_axi.arprot;
        end else begin
            ar_sel.port  = 1'b0;
            ar_sel.id    = s0_axi.arid;
            ar_sel.addr  = s0_axi.araddr;
            ar_sel.len   = s0_axi.arlen;
            ar_sel.size  = s0_axi.arsize;
            ar_sel.burst = s0_axi.arburst;
            ar_sel.lock  = s0_axi.arlock;
            ar_sel.cache = s0_axi.arcache;
            ar_sel.prot  = s0_axi.arprot;
        end
    end

    // NOTE: the payload register has no reset; it is only observed while
    // arvalid (driven by the reset state) is high, so clearing it is wasted.
    always_ff @(posedge aclk) begin
        if (grant_en) begin
            ar_q <= ar_sel;
        end
    end

    // Exactly one port can be granted per cycle, and only when it is valid.
    assign s0_axi.arready = grant_en && !grant_port;
    assign s1_axi.arready = grant_en &&  grant_port;

    assign m_axi.arvalid  = (state == ISSUE);
    assign m_axi.arid     = {ar_q.port, ar_q.id};
    assign m_axi.araddr   = ar_q.addr;
    assign m_axi.arlen    = ar_q.len;
    assign m_axi.arsize   = ar_q.size;
    assign m_axi.arburst  = ar_q.burst;
    assign m_axi.arlock   = ar_q.lock;
    assign m_axi.arcache  = ar_q.cache;
    assign m_axi.arprot   = ar_q.prot;

    // ------------------------------------------------------------------------
    // R channel routing (purely combinational)
    // ------------------------------------------------------------------------
    // The extra top ID bit names the requester that issued the burst.
    assign r_sel = m_axi.rid[ID_WIDTH];

    assign s0_axi.rvalid = m_axi.rvalid && !r_sel;
    assign s1_axi.rvalid = m_axi.rvalid &&  r_sel;

    assign s0_axi.rid    = m_axi.rid[ID_WIDTH-1:0];
    assign s1_axi.rid    = m_axi.rid[ID_WIDTH-1:0];
    assign s0_axi.rdata  = m_axi.rdata;
    assign s1_axi.rdata  = m_axi.rdata;
    assign s0_axi.rresp  = m_axi.rresp;
    assign s1_axi.rresp  = m_axi.rresp;
    assign s0_axi.rlast  = m_axi.rlast;
    assign s1_axi.rlast  = m_axi.rlast;

    assign m_axi.rready  = r_sel ? s1_axi.rready : s0_axi.rready;

endmodule
